// File: rtl/axi4_operand_master_if.sv
// AXI4 channel bundle between the operand master and the interconnect.
// Parameters: ASZ address width, DSZ data beat width.
// Modports: master (drives AW/W/AR, bready/rready), slave (mirror).
interface axi4_operand_master_if #(
  parameter int unsigned ASZ = 2,
  parameter int unsigned DSZ = 8
);
  logic [ASZ-1:0] awaddr;
  logic [7:0]     awlen;
  logic           awvalid;
  logic           awready;
  logic [DSZ-1:0] wdata;
  logic           wvalid;
  logic           wlast;
  logic           wready;
  logic           bresp;
  logic           bvalid;
  logic           bready;
  logic [ASZ-1:0] araddr;
  logic [7:0]     arlen;
  logic           arvalid;
  logic           arready;
  logic [DSZ-1:0] rdata;
  logic           rvalid;
  logic           rlast;
  logic           rresp;
  logic           rready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
           araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
           araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/axi4_operand_master.sv
// AXI4 master: writes NOPS operands (one burst each, LS beat first), then
// reads back a RESW-bit result into res.
// Ports: clk, rst (sync, active high), start/busy handshake, ops (latched
// at start), res/res_valid/res_err, axi (master modport).
// Optional: define AXI4M_RESP_RETRY_EN to retry failed bursts up to 3 times;
// otherwise the first failed burst ends the sequence with res_err.
module axi4_operand_master #(
  parameter int unsigned OPW      = 32,
  parameter int unsigned NOPS     = 2,
  parameter int unsigned DSZ      = 8,
  parameter int unsigned ASZ      = 2,
  parameter int unsigned RESW     = 64,
  parameter int unsigned RES_ADDR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NOPS*OPW-1:0]  ops,
  output logic [RESW-1:0]      res,
  output logic                 res_valid,
  output logic                 res_err,
  output logic                 busy,
  axi4_operand_master_if.master axi
);

  localparam int unsigned WBEATS     = OPW / DSZ;
  localparam int unsigned RBEATS     = RESW / DSZ;
  localparam logic [7:0]  WLAST_BEAT = 8'(WBEATS - 1);
  localparam logic [7:0]  RLAST_BEAT = 8'(RBEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ASZ-1:0]      opidx_q, opidx_d;
  logic [7:0]          beat_q, beat_d;
  logic [NOPS*OPW-1:0] ops_q, ops_d;
  logic [RESW-1:0]     res_q, res_d;
  logic                res_valid_q, res_valid_d;
  logic                res_err_q, res_err_d;
  logic                busy_q, busy_d;
  logic                rerr_q, rerr_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                wlast_q, wlast_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ASZ-1:0]      awaddr_q, awaddr_d;
  logic [ASZ-1:0]      araddr_q, araddr_d;
  logic [DSZ-1:0]      wdata_q, wdata_d;
`ifdef AXI4M_RESP_RETRY_EN
  localparam logic [3:0] RETRY_MAX = 4'd3;
  logic [3:0]          retry_q, retry_d;
`endif

  logic [7:0]          nbeat;
  logic [31:0]         wsh;
  logic [31:0]         rsh;
  logic [DSZ-1:0]      wbeat;
  logic                last_rbeat;
  logic                rerr_now;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    opidx_d     = opidx_q;
    beat_d      = beat_q;
    ops_d       = ops_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    busy_d      = busy_q;
    rerr_d      = rerr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
`ifdef AXI4M_RESP_RETRY_EN
    retry_d     = retry_q;
`endif

    // Index of the write beat presented next (0 when entering W)
    nbeat = 8'd0;
    if (state_q == S_W && beat_q != WLAST_BEAT) nbeat = beat_q + 8'd1;
    wsh        = 32'(opidx_q) * OPW + 32'(nbeat) * DSZ;
    wbeat      = DSZ'(ops_q >> wsh);
    rsh        = 32'(beat_q) * DSZ;
    last_rbeat = (beat_q == RLAST_BEAT);
    // rlast must coincide exactly with the final expected beat
    rerr_now   = rerr_q | ~axi.rresp | (axi.rlast ^ last_rbeat);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d     = S_AW;
          ops_d       = ops;
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          busy_d      = 1'b1;
          opidx_d     = '0;
          awaddr_d    = '0;
          awvalid_d   = 1'b1;
`ifdef AXI4M_RESP_RETRY_EN
          retry_d     = '0;
`endif
        end
      end
      S_AW: begin
        if (axi.awready) begin
          state_d   = S_W;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = 8'd0;
          wdata_d   = wbeat;
          wlast_d   = (WLAST_BEAT == 8'd0);
        end
      end
      S_W: begin
        if (axi.wready) begin
          if (wlast_q) begin
            state_d  = S_B;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            beat_d  = nbeat;
            wdata_d = wbeat;
            wlast_d = (nbeat == WLAST_BEAT);
          end
        end
      end
      S_B: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          if (axi.bresp) begin
`ifdef AXI4M_RESP_RETRY_EN
            retry_d = '0;
`endif
            if (opidx_q == ASZ'(NOPS - 1)) begin
              state_d   = S_AR;
              arvalid_d = 1'b1;
              araddr_d  = ASZ'(RES_ADDR);
            end else begin
              state_d   = S_AW;
              opidx_d   = opidx_q + ASZ'(1);
              awaddr_d  = opidx_q + ASZ'(1);
              awvalid_d = 1'b1;
            end
          end else begin
`ifdef AXI4M_RESP_RETRY_EN
            if (retry_q == RETRY_MAX) begin
              state_d     = S_DONE;
              busy_d      = 1'b0;
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
            end else begin
              // Same operand again from beat 0
              retry_d   = retry_q + 4'd1;
              state_d   = S_AW;
              awvalid_d = 1'b1;
            end
`else
            state_d     = S_DONE;
            busy_d      = 1'b0;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
`endif
          end
        end
      end
      S_AR: begin
        if (axi.arready) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = 8'd0;
          rerr_d    = 1'b0;
        end
      end
      S_R: begin
        if (axi.rvalid) begin
          res_d = (res_q & ~(RESW'({DSZ{1'b1}}) << rsh)) | (RESW'(axi.rdata) << rsh);
          if (axi.rlast || last_rbeat) begin
            rready_d = 1'b0;
            if (!rerr_now) begin
              state_d     = S_DONE;
              busy_d      = 1'b0;
              res_valid_d = 1'b1;
              res_err_d   = 1'b0;
`ifdef AXI4M_RESP_RETRY_EN
              retry_d     = '0;
`endif
            end else begin
`ifdef AXI4M_RESP_RETRY_EN
              if (retry_q == RETRY_MAX) begin
                state_d     = S_DONE;
                busy_d      = 1'b0;
                res_valid_d = 1'b1;
                res_err_d   = 1'b1;
              end else begin
                retry_d   = retry_q + 4'd1;
                state_d   = S_AR;
                arvalid_d = 1'b1;
              end
`else
              state_d     = S_DONE;
              busy_d      = 1'b0;
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
`endif
            end
          end else begin
            beat_d = beat_q + 8'd1;
            rerr_d = rerr_now;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opidx_q     <= '0;
      beat_q      <= '0;
      ops_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      rerr_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
`ifdef AXI4M_RESP_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      opidx_q     <= opidx_d;
      beat_q      <= beat_d;
      ops_q       <= ops_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      rerr_q      <= rerr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
`ifdef AXI4M_RESP_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign res         = res_q;
  assign res_valid   = res_valid_q;
  assign res_err     = res_err_q;
  assign busy        = busy_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'(WBEATS - 1);
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(RBEATS - 1);
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_operand_master.sv
// Randomized bench for axi4_operand_master: reactive AXI slave with stalls
// and fault injection, plus a transaction-level model of the expected bursts.
module tb_axi4_operand_master;
  localparam int unsigned OPW = 32, NOPS = 2, DSZ = 8, ASZ = 2, RESW = 64, RES_ADDR = 2;
  localparam int NW = OPW / DSZ;
  localparam int NR = RESW / DSZ;
`ifdef AXI4M_RESP_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                start;
  logic [NOPS*OPW-1:0] ops;
  logic [RESW-1:0]     res;
  logic                res_valid, res_err, busy;

  axi4_operand_master_if #(.ASZ(ASZ), .DSZ(DSZ)) ax ();

  axi4_operand_master #(
    .OPW(OPW), .NOPS(NOPS), .DSZ(DSZ), .ASZ(ASZ), .RESW(RESW), .RES_ADDR(RES_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ops(ops), .res(res),
    .res_valid(res_valid), .res_err(res_err), .busy(busy), .axi(ax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation
  int          mode;                 // 0 zero-wait, 1 alternate stall, 2 random stall
  int          bfail_lo, bfail_n;    // write responses [lo, lo+n) return bresp=0
  int          rfail_n, rkind, rk;   // first rfail_n reads fail: kind 0 early rlast at rk, 1 rresp=0 at rk
  logic [7:0]  rdq[32];              // read data per attempt*NR + beat
  int          bidx, r_att_n, r_att_cur, rbeat;
  bit          r_active, b_fire, w_fire, w_fire_last, ar_fire, r_fire, r_fire_last;
  bit          phase, w_stall_prev;
  logic [7:0]  wdata_prev;
  logic        wlast_prev;
  int          obs_aw[$];
  logic [8:0]  obs_w[$];
  int          obs_ar_n, obs_rbeats, obs_b_n;

  initial begin
    bit stall;
    bit bad;
    ax.awready = 0; ax.wready = 0; ax.bvalid = 0; ax.bresp = 0; ax.arready = 0;
    ax.rvalid = 0; ax.rdata = 0; ax.rlast = 0; ax.rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ax.awready = 0; ax.wready = 0; ax.bvalid = 0; ax.bresp = 0; ax.arready = 0;
        ax.rvalid = 0; ax.rlast = 0; ax.rresp = 0;
        r_active = 0; b_fire = 0; w_fire = 0; w_fire_last = 0; ar_fire = 0;
        r_fire = 0; r_fire_last = 0; w_stall_prev = 0;
        continue;
      end
      chk("one_channel", 64'($countones({ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready}) <= 1), 1);
      if (w_stall_prev) begin
        chk("wdata_hold", ax.wdata, wdata_prev);
        chk("wlast_hold", ax.wlast, wlast_prev);
      end
      // retire handshakes completed at the previous edge
      if (b_fire) ax.bvalid = 0;
      if (w_fire && w_fire_last) begin
        ax.bvalid = 1;
        ax.bresp  = !(bidx >= bfail_lo && bidx < bfail_lo + bfail_n);
        bidx++;
      end
      if (ar_fire) begin r_active = 1; rbeat = 0; end
      if (r_fire) begin rbeat++; if (r_fire_last) r_active = 0; end
      // drive slave side for the coming edge
      phase = ~phase;
      stall = (mode == 1) ? phase : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      ax.awready = !stall;
      ax.wready  = !stall;
      ax.arready = !stall;
      ax.rvalid  = r_active && !stall;
      bad        = (r_att_cur < rfail_n);
      ax.rdata   = rdq[(r_att_cur * NR + rbeat) & 31];
      ax.rresp   = !(bad && rkind == 1 && rbeat == rk);
      ax.rlast   = (bad && rkind == 0) ? (rbeat == rk) : (rbeat == NR - 1);
      // record handshakes that complete at the coming edge
      if (ax.awvalid && ax.awready) begin
        obs_aw.push_back(int'(ax.awaddr));
        chk("awlen", ax.awlen, NW - 1);
      end
      w_fire = ax.wvalid && ax.wready;
      w_fire_last = ax.wlast;
      if (w_fire) obs_w.push_back({ax.wlast, ax.wdata});
      b_fire = ax.bvalid && ax.bready;
      if (b_fire) obs_b_n++;
      ar_fire = ax.arvalid && ax.arready;
      if (ar_fire) begin
        chk("araddr", ax.araddr, RES_ADDR);
        chk("arlen", ax.arlen, NR - 1);
        obs_ar_n++;
        r_att_cur = r_att_n;
        r_att_n++;
      end
      r_fire = ax.rvalid && ax.rready;
      r_fire_last = ax.rlast;
      if (r_fire) obs_rbeats++;
      w_stall_prev = ax.wvalid && !ax.wready;
      wdata_prev   = ax.wdata;
      wlast_prev   = ax.wlast;
    end
  end

  // Transaction-level expectation
  logic [63:0] op_v;
  logic [63:0] res_m;
  int          exp_aw[$];
  logic [8:0]  exp_w[$];
  int          exp_ar_n, exp_rbeats, exp_b_n;
  bit          exp_err;

  task automatic build_model();
    int b;
    bit bad;
    int n;
    exp_aw.delete(); exp_w.delete();
    exp_ar_n = 0; exp_rbeats = 0; exp_b_n = 0; exp_err = 0; b = 0;
    for (int i = 0; i < NOPS && !exp_err; i++) begin
      for (int a = 0; a < 4; a++) begin
        exp_aw.push_back(i);
        for (int k = 0; k < NW; k++)
          exp_w.push_back({(k == NW - 1), 8'(op_v >> (i * OPW + k * DSZ))});
        bad = (b >= bfail_lo && b < bfail_lo + bfail_n);
        b++;
        exp_b_n++;
        if (!bad) break;
        if (!RETRY || a == 3) begin exp_err = 1; break; end
      end
    end
    if (!exp_err) begin
      for (int a = 0; a < 4; a++) begin
        exp_ar_n++;
        bad = (a < rfail_n);
        n = (bad && rkind == 0) ? rk + 1 : NR;
        for (int j = 0; j < n; j++)
          res_m = (res_m & ~(64'hFF << (8 * j))) | (64'(rdq[a * NR + j]) << (8 * j));
        exp_rbeats += n;
        if (!bad) break;
        if (!RETRY || a == 3) begin exp_err = 1; break; end
      end
    end
  endtask

  task automatic clear_obs();
    obs_aw.delete(); obs_w.delete();
    obs_ar_n = 0; obs_rbeats = 0; obs_b_n = 0;
    bidx = 0; r_att_n = 0; r_att_cur = 0;
  endtask

  task automatic run_seq(input bit dup);
    bit ok;
    build_model();
    clear_obs();
    ops = op_v; start = 1;
    @(negedge clk); #1;
    start = 0;
    chk("busy_on_start", busy, 1);
    chk("res_valid_cleared", res_valid, 0);
    if (dup) begin
      repeat (2) begin @(negedge clk); #1; end
      ops = ~op_v; start = 1;
      @(negedge clk); #1;
      start = 0;
    end
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (res_valid && !busy) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk("done_timeout", ok, 1);
    chk("res_valid", res_valid, 1);
    chk("res_err", res_err, exp_err);
    chk("res", res, res_m);
    repeat (4) begin @(negedge clk); #1; end
    chk("rready_idle", ax.rready, 0);
    chk("aw_count", obs_aw.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < obs_aw.size(); i++) chk("awaddr", obs_aw[i], exp_aw[i]);
    chk("w_count", obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) chk("wbeat", obs_w[i], exp_w[i]);
    chk("b_count", obs_b_n, exp_b_n);
    chk("ar_count", obs_ar_n, exp_ar_n);
    chk("r_beats", obs_rbeats, exp_rbeats);
  endtask

  task automatic check_reset_outputs();
    chk("rst_awvalid", ax.awvalid, 0);
    chk("rst_wvalid", ax.wvalid, 0);
    chk("rst_wlast", ax.wlast, 0);
    chk("rst_bready", ax.bready, 0);
    chk("rst_arvalid", ax.arvalid, 0);
    chk("rst_rready", ax.rready, 0);
    chk("rst_awaddr", ax.awaddr, 0);
    chk("rst_araddr", ax.araddr, 0);
    chk("rst_wdata", ax.wdata, 0);
    chk("rst_res", res, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic no_faults();
    bfail_lo = 0; bfail_n = 0; rfail_n = 0; rkind = 0; rk = 0;
  endtask

  task automatic fill_rdq();
    for (int i = 0; i < 32; i++) rdq[i] = 8'($urandom);
  endtask

  initial begin
    bit ok;
    int f;
    rst = 1; start = 0; ops = '0; mode = 0; res_m = '0;
    no_faults(); fill_rdq(); clear_obs();
    repeat (3) begin @(negedge clk); #1; end
    check_reset_outputs();
    rst = 0;
    @(negedge clk); #1;

    // Directed: known operands and result, zero-wait then alternate stalls
    op_v = {32'h08070605, 32'h04030201};
    for (int j = 0; j < NR; j++) rdq[j] = 8'((j + 1) * 8'h11);
    run_seq(0);
    chk("res_directed", res, 64'h8877665544332211);
    mode = 1;
    run_seq(1);
    chk("res_directed_stall", res, 64'h8877665544332211);

    // Write response error on operand 1
    mode = 0; fill_rdq(); bfail_lo = 1; bfail_n = 1;
    run_seq(0);

    // Early rlast on read beat 5
    no_faults(); fill_rdq(); rfail_n = 1; rkind = 0; rk = 5;
    run_seq(0);

    // Randomized sequences
    for (int t = 0; t < 14; t++) begin
      op_v = {$urandom, $urandom};
      fill_rdq(); no_faults();
      mode = $urandom_range(0, 2);
      f = $urandom_range(0, 4);
      if (f == 2) begin bfail_lo = $urandom_range(0, NOPS); bfail_n = $urandom_range(1, 4); end
      if (f == 3) begin rfail_n = $urandom_range(1, 4); rkind = 0; rk = $urandom_range(0, NR - 2); end
      if (f == 4) begin rfail_n = $urandom_range(1, 4); rkind = 1; rk = $urandom_range(0, NR - 1); end
      run_seq(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a write burst
    no_faults(); mode = 0; fill_rdq(); clear_obs();
    op_v = {$urandom, $urandom};
    ops = op_v; start = 1;
    @(negedge clk); #1;
    start = 0;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (obs_w.size() >= 2) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk("reach_w_beat2", ok, 1);
    rst = 1;
    @(negedge clk); #1;
    check_reset_outputs();
    rst = 0;
    res_m = '0;
    @(negedge clk); #1;

    // Recovery after reset
    op_v = {$urandom, $urandom};
    mode = 2;
    run_seq(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_operand_master.md
Name: axi4_operand_master

Overview:
- Parametrised AXI4 master that moves NOPS operands of OPW bits to a slave-side compute unit.
- Each operand goes out as one fixed-length write burst.
- After all writes, one read burst fetches the RESW-bit result, which is assembled into res.
- Sits between the operand-producing datapath and the AXI4 interconnect. Generalises the fixed two-operand, byte-beat, write-only master with configurable width, operand count, result read-back, response checking and a start/busy handshake.

Parameters:
OPW, 32, operand width in bits; multiple of DSZ
NOPS, 2, number of operands; one write burst each
DSZ, 8, AXI data beat width in bits
ASZ, 2, address width; must hold NOPS and RES_ADDR
RESW, 64, result width in bits; multiple of DSZ
RES_ADDR, 2, read address of result (default = NOPS)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin sequence; accepted only when busy=0
ops  in  NOPS*OPW  operands; operand i = ops[i*OPW +: OPW], sampled at start accept
res  out  RESW  assembled result
res_valid  out  1  result valid, level
res_err  out  1  sequence ended on error
busy  out  1  sequence in progress
awaddr  out  ASZ  write burst address = operand index
awlen  out  8  OPW/DSZ-1
awvalid  out  1  / awready in 1
wdata  out  DSZ  / wvalid out 1 / wlast out 1 / wready in 1
bresp  in  1  1 => ok / bvalid in 1 / bready out 1
araddr  out  ASZ  = RES_ADDR / arlen out 8 = RESW/DSZ-1 / arvalid out 1 / arready in 1
rdata  in  DSZ  / rvalid in 1 / rlast in 1 / rresp in 1 (1 => ok) / rready out 1

Behaviour:
- Reset (rst high at clk edge): state IDLE; every valid/ready/last output 0, awaddr/araddr/wdata 0, res 0, res_valid 0, res_err 0, busy 0.
- Reset mid-operation aborts immediately, with no burst completion. Outputs take reset values on that edge.
- IDLE: start=1 latches ops, clears res_valid/res_err, sets busy=1, opidx=0, goes to AW. start while busy=1 is ignored.
- AW: awvalid=1, awaddr=opidx. On awvalid&awready -> W, beat=0, wdata=beat 0.
- W: wvalid=1. Beat k = op[opidx][k*DSZ +: DSZ], LS beat first.
  - wlast=1 exactly on beat OPW/DSZ-1.
  - wdata/wlast held stable while wready=0.
  - On wvalid&wready&wlast: wvalid=0, go to B.
- B: bready=1. On bvalid:
  - bresp=1: opidx+1; if opidx was NOPS-1 go to AR, else AW.
  - bresp=0: error handling (see Optional Feature).
- AR: arvalid=1, araddr=RES_ADDR. On arready -> R, rbeat=0.
- R: rready=1. Each rvalid beat j writes rdata into res[j*DSZ +: DSZ] directly. Any rresp=0 beat sets a sticky burst error.
  - Burst ends on rvalid&rlast.
  - rlast with j != RESW/DSZ-1, or no rlast on beat RESW/DSZ-1 (beat count exceeded), is a burst error. Burst terminates at that beat.
- DONE (1 cycle): busy=0, res_valid=1 (held until next accepted start or reset), res_err as accumulated. Then IDLE.
- Only one AXI channel is active at a time. AW and AR are never concurrent.
- valid outputs never drop before their handshake completes.
- A one-cycle gap between bursts is allowed. Minimum latency from start to res_valid is NOPS*(OPW/DSZ+3)+RESW/DSZ+3 cycles with a zero-wait slave.

Optional Feature:
Macro AXI4M_RESP_RETRY_EN.
- Defined:
  - A write burst with bresp=0 re-issues AW for the same opidx, data re-sent from beat 0.
  - A read burst error re-issues AR.
  - Up to 3 retries per burst (4-bit counter per burst, cleared on success). After the 3rd failed retry, go to DONE with res_err=1, res_valid=1.
- Not defined:
  - The first bresp=0 goes straight to DONE with res_err=1; the remaining operands and the read are skipped.
  - A read burst error goes to DONE with res_err=1; res holds whatever beats were written.

Test Plan:
- ops={32'h08070605,32'h04030201}, zero-wait slave returning rdata 11,22,...,88 -> AW addr0 awlen3; W 01,02,03,04 with wlast on 04; AW addr1; W 05..08; AR addr2 arlen7; res=64'h8877665544332211, res_valid=1, res_err=0.
- Same stimulus, awready/wready/arready/rvalid low on alternate cycles -> identical beat sequence, wdata stable during stalls, same res.
- bresp=0 on operand 1 -> without macro: no AR issued, res_err=1, res_valid=1. With macro, slave ok on 2nd attempt: AW addr1 reissued, beats 05..08 resent, res_err=0.
- Slave asserts rlast on read beat 5 -> res_err=1, res_valid=1, no rready after that beat; under macro, AR reissued.
- rst pulsed mid W burst (beat 2), start pulsed while busy -> outputs at reset values on the reset edge, busy=0; mid-sequence start ignored (no extra AW).
